// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and integer register file.
// No logic; widths and named encodings only.
// Not applicable: no handshake.
package wb_regfile_pkg;

    localparam int WB_DATA_WIDTH  = 32;
    localparam int WB_RADDR_WIDTH = 5;
    localparam int WB_REG_NUM     = 32;
    localparam int WB_CNT_WIDTH   = 32;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/wb_regfile_fwd_mux.sv
// Operand read select: x0, then execute result, then writeback stage, then array.
// Latency: combinational.
// Backpressure: none; the result follows the inputs every cycle.
module wb_regfile_fwd_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = WB_DATA_WIDTH,
    parameter int RADDR_WIDTH = WB_RADDR_WIDTH
) (
    input  logic [RADDR_WIDTH-1:0] raddr,
    input  logic                   ex_we,
    input  logic [RADDR_WIDTH-1:0] ex_waddr,
    input  logic [DATA_WIDTH-1:0]  ex_wdata,
    input  logic                   wb_we,
    input  logic [RADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0]  wb_wdata,
    input  logic [DATA_WIDTH-1:0]  arr_rdata,
    output logic [DATA_WIDTH-1:0]  rdata
);

    // The youngest producer wins: the execute result is newer than the stage.
    always_comb begin
        rdata = arr_rdata;
        if (raddr == '0) begin
            rdata = '0;
        end else if (ex_we && (ex_waddr == raddr)) begin
            rdata = ex_wdata;
        end else if (wb_we && (wb_waddr == raddr)) begin
            rdata = wb_wdata;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// One-entry writeback stage in front of a 32x32 register file, with two forwarded read ports.
// Latency: result in stage one cycle after execute; visible from the array two cycles after.
// Backpressure: hold_i freezes the stage and blocks commit; flush_i loads a bubble, commit still allowed.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = WB_DATA_WIDTH,
    parameter int RADDR_WIDTH = WB_RADDR_WIDTH,
    parameter int REG_NUM     = WB_REG_NUM,
    parameter int CNT_WIDTH   = WB_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    input  logic                   hold_i,
    input  logic                   flush_i,
    input  logic [RADDR_WIDTH-1:0] raddr1_i,
    input  logic [RADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0]  rdata1_o,
    output logic [DATA_WIDTH-1:0]  rdata2_o,
    output logic                   wb_we_o,
    output logic [RADDR_WIDTH-1:0] wb_waddr_o,
    output logic [DATA_WIDTH-1:0]  wb_wdata_o,
    output logic [CNT_WIDTH-1:0]   commit_cnt_o
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic                  cap_we;
    logic                  commit;
    logic [DATA_WIDTH-1:0] arr_rdata1;
    logic [DATA_WIDTH-1:0] arr_rdata2;

    // x0 writes die here so they never reach the stage, the array or the counter.
    assign cap_we = (reg_we_i == WRITE_ENABLE) && (reg_waddr_i != '0);
    assign commit = wb_we_o && (flush_i || !hold_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_we_o    <= WRITE_DISABLE;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
        end else if (flush_i) begin
            wb_we_o    <= WRITE_DISABLE;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
        end else if (!hold_i) begin
            wb_we_o    <= cap_we;
            wb_waddr_o <= reg_waddr_i;
            wb_wdata_o <= reg_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_waddr_o] <= wb_wdata_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            commit_cnt_o <= '0;
        end else if (commit) begin
            commit_cnt_o <= commit_cnt_o + CNT_WIDTH'(1);
        end
    end

    assign arr_rdata1 = regs[raddr1_i];
    assign arr_rdata2 = regs[raddr2_i];

    wb_regfile_fwd_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RADDR_WIDTH (RADDR_WIDTH)
    ) u_fwd1 (
        .raddr     (raddr1_i),
        .ex_we     (cap_we),
        .ex_waddr  (reg_waddr_i),
        .ex_wdata  (reg_wdata_i),
        .wb_we     (wb_we_o),
        .wb_waddr  (wb_waddr_o),
        .wb_wdata  (wb_wdata_o),
        .arr_rdata (arr_rdata1),
        .rdata     (rdata1_o)
    );

    wb_regfile_fwd_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RADDR_WIDTH (RADDR_WIDTH)
    ) u_fwd2 (
        .raddr     (raddr2_i),
        .ex_we     (cap_we),
        .ex_waddr  (reg_waddr_i),
        .ex_wdata  (reg_wdata_i),
        .wb_we     (wb_we_o),
        .wb_waddr  (wb_waddr_o),
        .wb_wdata  (wb_wdata_o),
        .arr_rdata (arr_rdata2),
        .rdata     (rdata2_o)
    );

endmodule
